ldst_sequencer: RTL and testbench
=================================

// Module: ldst_sequencer
// PURPOSE
//  Control sequencer that drives the DataMemory/RegisterFile datapath control inputs.
//  Runs burst transfers between DataMemory and RegisterFile in either direction:
//   - LOAD: memory -> register file.
//   - STORE: register file port A -> memory.
//  Accepts one command via a start/busy/done handshake and hides the 1-cycle RAM read latency.
// PARAMETERS
//  MEM_AW  8  DataMemory address width (256 words)
//  REG_AW  4  RegisterFile address width (16 registers)
//  LEN_W   4  burst-length field width; words per burst = len_m1+1 (1..16)
// PORTS
//  clk         in   1       system clock, all state updates on posedge
//  reset       in   1       synchronous, active-high reset
//  start       in   1       command strobe, sampled only in IDLE
//  op          in   1       0 = LOAD (mem->RF), 1 = STORE (RF->mem)
//  mem_addr    in   MEM_AW  first memory word address
//  reg_addr    in   REG_AW  first register index
//  len_m1      in   LEN_W   burst length minus one
//  busy        out  1       high in every state except IDLE
//  done        out  1       one-cycle pulse when the burst completes
//  D_addr      out  MEM_AW  DataMemory address
//  D_W_en      out  1       DataMemory write enable
//  RF_W_en     out  1       RegisterFile write enable
//  RF_W_addr   out  REG_AW  RegisterFile write address
//  RF_Ra_addr  out  REG_AW  RegisterFile read-port-A address (source of store data)
// BEHAVIOUR
//  Reset: sync active-high; state=IDLE next edge.
//   - All outputs 0: busy, done, D_W_en, RF_W_en, D_addr, RF_W_addr, RF_Ra_addr.
//   - Reset mid-burst aborts: no further writes after the reset edge, no done pulse.
//  Outputs are decoded from registered state/counters only; no start->output comb path.
//  IDLE: start=1 latches op, mem_addr, reg_addr, len_m1 into cur_m, cur_r, rem.
//   - Next state: LD_ADDR if op=0, ST_WR if op=1.
//   - start is ignored in any other state; new inputs are not latched.
//  LD_ADDR: D_addr=cur_m, D_W_en=0, RF_W_en=0; the RAM captures the address on this edge.
//   - Next state: LD_WB.
//  LD_WB: D_addr=cur_m (held), RF_W_en=1, RF_W_addr=cur_r; the RF writes RAM q on this edge.
//   - Then cur_m+=1, cur_r+=1.
//   - rem==0 -> DONE; else rem-=1 and go to LD_ADDR.
//  ST_WR: D_addr=cur_m, RF_Ra_addr=cur_r, D_W_en=1, RF_W_en=0; the RAM writes RF A on this edge.
//   - Then increment cur_m/cur_r as for LD_WB.
//   - rem==0 -> DONE; else rem-=1 and stay in ST_WR.
//  DONE: done=1, busy=1, all write enables 0; next state IDLE unconditionally.
//  Latency from the start edge to the done cycle:
//   - LOAD: 2*(len_m1+1) cycles.
//   - STORE: len_m1+1 cycles.
//   - IDLE is re-entered one cycle after done; back-to-back commands are accepted then.
//  Arithmetic and width rules:
//   - Address counters wrap modulo 2^MEM_AW and 2^REG_AW (0xFF->0x00, 0xF->0x0).
//   - rem is LEN_W bits and never underflows.
//  Register 0 has no special handling: it is loadable and storable like any other register.
//  D_W_en and RF_W_en are never high in the same cycle.
//  The address outputs hold their last value in IDLE/DONE; only the enables are forced to 0.
// STRUCTURE
//  ldst_pkg:
//   - typedef enum logic [2:0] {IDLE, LD_ADDR, LD_WB, ST_WR, DONE} ldst_state_t.
//   - typedef enum logic {OP_LOAD=0, OP_STORE=1} ldst_op_t.
//   - MEM_AW/REG_AW/LEN_W default localparams.
//  One sub-module, xfer_addr_gen:
//   - Holds cur_m, cur_r and rem.
//   - Ports: load, step, last.
//  The FSM lives in ldst_sequencer; the bench wraps it with DataMemory + RegisterFile.
// TESTING
//  1 STORE single: preload R3=16'h1234; start op=1, mem=8'h10, reg=3, len_m1=0.
//    -> D_W_en high exactly 1 cycle with D_addr=0x10.
//    -> done on cycle 1 after start; mem[0x10]=0x1234.
//  2 LOAD burst: mem[0x20..0x23]=A0,A1,A2,A3; start op=0, mem=0x20, reg=4, len_m1=3.
//    -> R4..R7=A0..A3; RF_W_en pulses 4 times, every other cycle; done at cycle 8.
//  3 Wrap: LOAD mem=0xFE, reg=0xF, len_m1=2.
//    -> reads 0xFE,0xFF,0x00 into R15,R0,R1.
//  4 Busy ignore: pulse start with op=1, mem=0x55 during test 2's burst.
//    -> no D_W_en, the burst is unaffected, exactly one done.
//  5 Reset mid-burst: assert reset after the 2nd RF_W_en of an 8-word LOAD.
//    -> next cycle all outputs 0, IDLE.
//    -> only 2 registers modified, no done pulse.
//  6 Back-to-back: a STORE started in the cycle after done is accepted.
//    -> total 2 done pulses, correct memory contents.

Source files
------------

// File: rtl/ldst_pkg.sv
// Shared types and default widths for the load/store burst sequencer.
// Imported by xfer_addr_gen and ldst_sequencer.
package ldst_pkg;

  localparam int LDST_MEM_AW = 8;
  localparam int LDST_REG_AW = 4;
  localparam int LDST_LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LD_ADDR,
    LD_WB,
    ST_WR,
    DONE
  } ldst_state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } ldst_op_t;

endpackage

// File: rtl/xfer_addr_gen.sv
// Burst address/length counters: cur_m, cur_r, rem.
// Ports: load latches a command, step advances one word, last flags rem==0.
module xfer_addr_gen
  import ldst_pkg::*;
#(
  parameter int MEM_AW = LDST_MEM_AW,
  parameter int REG_AW = LDST_REG_AW,
  parameter int LEN_W  = LDST_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic [LEN_W-1:0]  len_m1,
  output logic [MEM_AW-1:0] cur_m,
  output logic [REG_AW-1:0] cur_r,
  output logic              last
);

  logic [LEN_W-1:0] rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_m <= '0;
      cur_r <= '0;
      rem   <= '0;
    end else if (load) begin
      cur_m <= mem_addr;
      cur_r <= reg_addr;
      rem   <= len_m1;
    end else if (step) begin
      // addresses wrap naturally at their widths
      cur_m <= cur_m + 1'b1;
      cur_r <= cur_r + 1'b1;
      if (rem != '0)
        rem <= rem - 1'b1;
    end
  end

  assign last = (rem == '0);

endmodule

// File: rtl/ldst_sequencer.sv
// Burst sequencer driving DataMemory/RegisterFile control for LOAD/STORE.
// Ports: start/op/mem_addr/reg_addr/len_m1 in; busy/done, D_*/RF_* controls out.
module ldst_sequencer
  import ldst_pkg::*;
#(
  parameter int MEM_AW = LDST_MEM_AW,
  parameter int REG_AW = LDST_REG_AW,
  parameter int LEN_W  = LDST_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic [LEN_W-1:0]  len_m1,
  output logic              busy,
  output logic              done,
  output logic [MEM_AW-1:0] D_addr,
  output logic              D_W_en,
  output logic              RF_W_en,
  output logic [REG_AW-1:0] RF_W_addr,
  output logic [REG_AW-1:0] RF_Ra_addr
);

  ldst_state_t state_q, state_d;

  logic              load, step, last;
  logic [MEM_AW-1:0] cur_m;
  logic [REG_AW-1:0] cur_r;

  logic s_ld_addr, s_ld_wb, s_st_wr, s_done;

  logic [MEM_AW-1:0] d_hold;
  logic [REG_AW-1:0] rfw_hold, rfa_hold;

  assign load = (state_q == IDLE) && start;
  assign step = s_ld_wb || s_st_wr;

  xfer_addr_gen #(
    .MEM_AW(MEM_AW),
    .REG_AW(REG_AW),
    .LEN_W (LEN_W)
  ) u_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .mem_addr(mem_addr),
    .reg_addr(reg_addr),
    .len_m1  (len_m1),
    .cur_m   (cur_m),
    .cur_r   (cur_r),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (ldst_op_t'(op) == OP_STORE)
                  ? ST_WR : LD_ADDR;
      end
      LD_ADDR: state_d = LD_WB;
      LD_WB:   state_d = last ? DONE : LD_ADDR;
      ST_WR:   state_d = last ? DONE : ST_WR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ld_addr = 1'b0;
    s_ld_wb   = 1'b0;
    s_st_wr   = 1'b0;
    s_done    = 1'b0;
    unique case (state_q)
      LD_ADDR: s_ld_addr = 1'b1;
      LD_WB:   s_ld_wb   = 1'b1;
      ST_WR:   s_st_wr   = 1'b1;
      DONE:    s_done    = 1'b1;
      default: ;
    endcase
  end

  // Addresses keep their last driven value once the burst ends,
  // so a copy is captured every active cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_hold   <= '0;
      rfw_hold <= '0;
      rfa_hold <= '0;
    end else begin
      if (s_ld_addr || s_ld_wb || s_st_wr)
        d_hold <= cur_m;
      if (s_ld_addr || s_ld_wb)
        rfw_hold <= cur_r;
      if (s_st_wr)
        rfa_hold <= cur_r;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = s_done;
  assign D_W_en     = s_st_wr;
  assign RF_W_en    = s_ld_wb;
  assign D_addr     = (s_ld_addr || s_ld_wb || s_st_wr)
                    ? cur_m : d_hold;
  assign RF_W_addr  = (s_ld_addr || s_ld_wb)
                    ? cur_r : rfw_hold;
  assign RF_Ra_addr = s_st_wr ? cur_r : rfa_hold;

endmodule

// File: tb/tb_ldst_sequencer.sv
// Bench for ldst_sequencer wrapped with a DataMemory/RegisterFile model.
// Directed scenarios with hand-computed expectations.
module tb_ldst_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [7:0]  mem_addr;
  logic [3:0]  reg_addr;
  logic [3:0]  len_m1;
  logic        busy, done;
  logic [7:0]  D_addr;
  logic        D_W_en, RF_W_en;
  logic [3:0]  RF_W_addr, RF_Ra_addr;

  logic [15:0] mem [256];
  logic [15:0] rf  [16];
  logic [15:0] q;

  logic        pl_mem_we = 1'b0;
  logic        pl_rf_we  = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ldst_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .mem_addr  (mem_addr),
    .reg_addr  (reg_addr),
    .len_m1    (len_m1),
    .busy      (busy),
    .done      (done),
    .D_addr    (D_addr),
    .D_W_en    (D_W_en),
    .RF_W_en   (RF_W_en),
    .RF_W_addr (RF_W_addr),
    .RF_Ra_addr(RF_Ra_addr)
  );

  // DataMemory: sync write, registered read. RegisterFile: sync write, comb read A.
  always @(posedge clk) begin
    if (pl_mem_we) mem[pl_a] <= pl_d;
    else if (D_W_en) mem[D_addr] <= rf[RF_Ra_addr];
    q <= mem[D_addr];
    if (pl_rf_we) rf[pl_a[3:0]] <= pl_d;
    else if (RF_W_en) rf[RF_W_addr] <= q;
  end

  task automatic poke_mem(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_mem_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_mem_we = 1'b0;
  endtask

  task automatic poke_rf(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_rf_we = 1'b1; pl_a = {4'h0, a}; pl_d = d;
    @(negedge clk);
    pl_rf_we = 1'b0;
  endtask

  task automatic go(input logic o, input logic [7:0] m,
                    input logic [3:0] r, input logic [3:0] l);
    @(negedge clk);
    start = 1'b1; op = o; mem_addr = m; reg_addr = r; len_m1 = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // k counts clock edges after the start edge; done is seen at k == latency.
  task automatic run_cmd(input logic o, input logic [7:0] m,
                         input logic [3:0] r, input logic [3:0] l,
                         input int poke_at, input int tail,
                         output int lat, output int ndone,
                         output int n_dw, output int n_rw,
                         output logic [63:0] rw_mask,
                         output logic [7:0] dw_addr);
    int both;
    lat = -1; ndone = 0; n_dw = 0; n_rw = 0;
    rw_mask = '0; dw_addr = '0; both = 0;
    go(o, m, r, l);
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      if (k == poke_at) begin
        start = 1'b1; op = 1'b1; mem_addr = 8'h55;
      end else begin
        start = 1'b0;
      end
      if (D_W_en) begin n_dw++; dw_addr = D_addr; end
      if (RF_W_en) begin n_rw++; rw_mask[k] = 1'b1; end
      if (D_W_en && RF_W_en) both++;
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + tail) break;
    end
    start = 1'b0;
    vec++;
    if (lat < 0) begin
      bad++; $display("FAIL cmd_timeout: no done within budget");
    end
    vec++;
    if (both !== 0) begin
      bad++; $display("FAIL enable_overlap: got %0d cycles want 0", both);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0;
    mem_addr = '0; reg_addr = '0; len_m1 = '0;
    repeat (3) @(negedge clk);
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    vec++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    vec++; if (D_W_en !== 1'b0) begin bad++; $display("FAIL rst_dwen: got %b want 0", D_W_en); end
    vec++; if (RF_W_en !== 1'b0) begin bad++; $display("FAIL rst_rfwen: got %b want 0", RF_W_en); end
    vec++; if (D_addr !== 8'h00) begin bad++; $display("FAIL rst_daddr: got %h want 00", D_addr); end
    vec++; if (RF_W_addr !== 4'h0) begin bad++; $display("FAIL rst_rfwaddr: got %h want 0", RF_W_addr); end
    vec++; if (RF_Ra_addr !== 4'h0) begin bad++; $display("FAIL rst_rfraaddr: got %h want 0", RF_Ra_addr); end
    reset = 1'b0;
  endtask

  task automatic test_store_single;
    int lat, nd, ndw, nrw;
    logic [63:0] msk;
    logic [7:0] da;
    poke_rf(4'd3, 16'h1234);
    run_cmd(1'b1, 8'h10, 4'd3, 4'd0, -1, 3, lat, nd, ndw, nrw, msk, da);
    vec++; if (lat !== 1) begin bad++; $display("FAIL st1_latency: got %0d want 1", lat); end
    vec++; if (ndw !== 1) begin bad++; $display("FAIL st1_dwen_count: got %0d want 1", ndw); end
    vec++; if (da !== 8'h10) begin bad++; $display("FAIL st1_daddr: got %h want 10", da); end
    vec++; if (nrw !== 0) begin bad++; $display("FAIL st1_rfwen_count: got %0d want 0", nrw); end
    vec++; if (nd !== 1) begin bad++; $display("FAIL st1_done_count: got %0d want 1", nd); end
    vec++; if (mem[8'h10] !== 16'h1234) begin bad++; $display("FAIL st1_mem10: got %h want 1234", mem[8'h10]); end
    vec++; if (D_addr !== 8'h10) begin bad++; $display("FAIL st1_daddr_hold: got %h want 10", D_addr); end
  endtask

  task automatic test_load_burst_busy_ignore;
    int lat, nd, ndw, nrw;
    logic [63:0] msk;
    logic [7:0] da;
    poke_mem(8'h20, 16'hA0A0);
    poke_mem(8'h21, 16'hA1A1);
    poke_mem(8'h22, 16'hA2A2);
    poke_mem(8'h23, 16'hA3A3);
    poke_mem(8'h55, 16'h5555);
    run_cmd(1'b0, 8'h20, 4'd4, 4'd3, 3, 3, lat, nd, ndw, nrw, msk, da);
    vec++; if (rf[4] !== 16'hA0A0) begin bad++; $display("FAIL ld_r4: got %h want a0a0", rf[4]); end
    vec++; if (rf[5] !== 16'hA1A1) begin bad++; $display("FAIL ld_r5: got %h want a1a1", rf[5]); end
    vec++; if (rf[6] !== 16'hA2A2) begin bad++; $display("FAIL ld_r6: got %h want a2a2", rf[6]); end
    vec++; if (rf[7] !== 16'hA3A3) begin bad++; $display("FAIL ld_r7: got %h want a3a3", rf[7]); end
    vec++; if (lat !== 8) begin bad++; $display("FAIL ld_latency: got %0d want 8", lat); end
    vec++; if (nrw !== 4) begin bad++; $display("FAIL ld_rfwen_count: got %0d want 4", nrw); end
    vec++; if (msk !== 64'hAA) begin bad++; $display("FAIL ld_rfwen_pattern: got %h want aa", msk); end
    vec++; if (ndw !== 0) begin bad++; $display("FAIL ign_dwen_count: got %0d want 0", ndw); end
    vec++; if (nd !== 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", nd); end
    vec++; if (mem[8'h55] !== 16'h5555) begin bad++; $display("FAIL ign_mem55: got %h want 5555", mem[8'h55]); end
  endtask

  task automatic test_wrap;
    int lat, nd, ndw, nrw;
    logic [63:0] msk;
    logic [7:0] da;
    poke_mem(8'hFE, 16'hFEFE);
    poke_mem(8'hFF, 16'hFFFF);
    poke_mem(8'h00, 16'h0C0C);
    poke_rf(4'd2, 16'h2222);
    run_cmd(1'b0, 8'hFE, 4'hF, 4'd2, -1, 3, lat, nd, ndw, nrw, msk, da);
    vec++; if (rf[15] !== 16'hFEFE) begin bad++; $display("FAIL wrap_r15: got %h want fefe", rf[15]); end
    vec++; if (rf[0] !== 16'hFFFF) begin bad++; $display("FAIL wrap_r0: got %h want ffff", rf[0]); end
    vec++; if (rf[1] !== 16'h0C0C) begin bad++; $display("FAIL wrap_r1: got %h want 0c0c", rf[1]); end
    vec++; if (rf[2] !== 16'h2222) begin bad++; $display("FAIL wrap_r2: got %h want 2222", rf[2]); end
    vec++; if (lat !== 6) begin bad++; $display("FAIL wrap_latency: got %0d want 6", lat); end
    vec++; if (nrw !== 3) begin bad++; $display("FAIL wrap_rfwen_count: got %0d want 3", nrw); end
  endtask

  task automatic test_reset_mid_burst;
    int nrw, stray;
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      poke_mem(8'h40 + 8'(i), 16'h4000 + 16'(i));
      poke_rf(4'd8 + 4'(i), 16'h8800 + 16'(i));
    end
    nrw = 0; stray = 0;
    go(1'b0, 8'h40, 4'd8, 4'd7);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      if (RF_W_en) nrw++;
    end
    reset = 1'b1;
    @(negedge clk);
    vec++; if (nrw !== 2) begin bad++; $display("FAIL rmb_writes_before: got %0d want 2", nrw); end
    vec++;
    if ({busy, done, D_W_en, RF_W_en, D_addr, RF_W_addr, RF_Ra_addr} !== 20'h0) begin
      bad++;
      $display("FAIL rmb_outputs: got %b%b%b%b %h %h %h want all 0",
               busy, done, D_W_en, RF_W_en, D_addr, RF_W_addr, RF_Ra_addr);
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || D_W_en || RF_W_en || busy) stray++;
    end
    vec++; if (stray !== 0) begin bad++; $display("FAIL rmb_after_reset: got %0d active cycles want 0", stray); end
    vec++; if (rf[8] !== 16'h4000) begin bad++; $display("FAIL rmb_r8: got %h want 4000", rf[8]); end
    vec++; if (rf[9] !== 16'h4001) begin bad++; $display("FAIL rmb_r9: got %h want 4001", rf[9]); end
    for (int i = 10; i < 16; i++) begin
      exp = 16'h8800 + 16'(i - 8);
      vec++;
      if (rf[i] !== exp) begin
        bad++; $display("FAIL rmb_r%0d: got %h want %h", i, rf[i], exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat1, nd1, ndw1, nrw1;
    int lat2, nd2, ndw2, nrw2;
    logic [63:0] msk;
    logic [7:0] da;
    poke_rf(4'd2, 16'hB002);
    poke_rf(4'd3, 16'hB003);
    run_cmd(1'b1, 8'h80, 4'd2, 4'd1, -1, 0, lat1, nd1, ndw1, nrw1, msk, da);
    run_cmd(1'b1, 8'h90, 4'd4, 4'd1, -1, 3, lat2, nd2, ndw2, nrw2, msk, da);
    vec++; if (lat1 !== 2) begin bad++; $display("FAIL b2b_lat1: got %0d want 2", lat1); end
    vec++; if (lat2 !== 2) begin bad++; $display("FAIL b2b_lat2: got %0d want 2", lat2); end
    vec++; if (nd1 + nd2 !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", nd1 + nd2); end
    vec++; if (ndw1 + ndw2 !== 4) begin bad++; $display("FAIL b2b_dwen_count: got %0d want 4", ndw1 + ndw2); end
    vec++; if (mem[8'h80] !== 16'hB002) begin bad++; $display("FAIL b2b_mem80: got %h want b002", mem[8'h80]); end
    vec++; if (mem[8'h81] !== 16'hB003) begin bad++; $display("FAIL b2b_mem81: got %h want b003", mem[8'h81]); end
    vec++; if (mem[8'h90] !== 16'hA0A0) begin bad++; $display("FAIL b2b_mem90: got %h want a0a0", mem[8'h90]); end
    vec++; if (mem[8'h91] !== 16'hA1A1) begin bad++; $display("FAIL b2b_mem91: got %h want a1a1", mem[8'h91]); end
  endtask

  initial begin
    test_reset();
    test_store_single();
    test_load_burst_busy_ignore();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
